// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction-fetch front end: fetch entries, fetch FSM
// states and the reset PC default.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Clear the byte offset of a redirect target.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// Small synchronous FIFO of fetch entries with a synchronous clear; used for
// the prefetch buffer and for the per-transaction PC queue.
module instr_fetch_buffer
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PTR_W'(i)] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32 PC generation and instruction fetch: issues word reads on the ibus,
// buffers returned words and hands {pc, instr} to decode, squashing on flush.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        flush,
    input  logic        stall_n,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_busy
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_q;
    fetch_state_e     state_n;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      fetch_pc_n;
    logic [31:0]      deliver_pc_q;
    logic [31:0]      deliver_pc_n;
    logic [31:0]      redir_pc_q;
    logic [31:0]      redir_pc_n;
    logic [31:0]      target_c;
    logic             stale_q;
    logic             stale_n;
    logic [CNT_W-1:0] out_q;
    logic [CNT_W-1:0] out_n;
    logic [CNT_W-1:0] disc_q;
    logic [CNT_W-1:0] disc_n;
    logic [CNT_W-1:0] live_n;
    logic [CNT_W-1:0] fifo_cnt_n;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] pcq_count;
    logic             req_n;
    logic             busy_n;
    logic             flush_c;
    logic             gnt_c;
    logic             consume_c;
    logic             accept_c;
    logic             drop_c;
    logic             pcq_push_c;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_head;
    fetch_entry_t     pcq_wdata;
    fetch_entry_t     pcq_head;
    logic [31:0]      unused_pcq_instr;

    // A jump is always a redirect, so it squashes even if flush is missing.
    assign flush_c    = flush | jump;
    assign gnt_c      = ibus_req & ibus_gnt;
    assign consume_c  = instr_valid & stall_n & ~flush_c;
    assign pcq_push_c = gnt_c & ~stale_q & ~flush_c;

    assign pcq_wdata        = '{pc: fetch_pc_q, instr: '0};
    assign fifo_wdata       = '{pc: pcq_head.pc, instr: ibus_rdata};
    assign unused_pcq_instr = pcq_head.instr;

    // PC of every live in-flight transaction, in issue order.
    instr_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_c),
        .push  (pcq_push_c),
        .pop   (accept_c),
        .wdata (pcq_wdata),
        .rdata (pcq_head),
        .count (pcq_count)
    );

    instr_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_prefetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_c),
        .push  (accept_c),
        .pop   (consume_c),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign ibus_addr   = fetch_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_n;
        end
    end

    // Stay in DRAIN while any old-path response, granted or still pending, is owed.
    always_comb begin
        state_n = state_q;
        case (state_q)
            RUN:     if (flush_c && ((disc_n != '0) || stale_n)) state_n = DRAIN;
            DRAIN:   if ((disc_n == '0) && !stale_n) state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_comb begin
        accept_c = 1'b0;
        drop_c   = 1'b0;
        case (state_q)
            RUN: begin
                accept_c = ibus_rvalid && !flush_c && (pcq_count != '0);
            end
            DRAIN: begin
                drop_c   = ibus_rvalid && !flush_c && (disc_q != '0);
                accept_c = ibus_rvalid && !flush_c && (disc_q == '0) && (pcq_count != '0);
            end
            default: begin
                accept_c = 1'b0;
            end
        endcase
    end

    // Next-state datapath; a flush turns every outstanding transaction into a discard.
    always_comb begin
        target_c     = jump ? word_align(jump_addr) : deliver_pc_q;
        out_n        = out_q + CNT_W'(gnt_c) - CNT_W'(ibus_rvalid);
        fetch_pc_n   = fetch_pc_q;
        deliver_pc_n = deliver_pc_q;
        redir_pc_n   = redir_pc_q;
        stale_n      = stale_q;
        disc_n       = disc_q;
        fifo_cnt_n   = fifo_count + CNT_W'(accept_c) - CNT_W'(consume_c);
        if (flush_c) begin
            disc_n       = out_n;
            stale_n      = ibus_req && !ibus_gnt;
            redir_pc_n   = target_c;
            deliver_pc_n = target_c;
            fifo_cnt_n   = '0;
            if (!stale_n) begin
                fetch_pc_n = target_c;
            end
        end else begin
            disc_n = disc_q + CNT_W'(gnt_c && stale_q) - CNT_W'(drop_c);
            if (gnt_c) begin
                stale_n    = 1'b0;
                fetch_pc_n = stale_q ? redir_pc_q : fetch_pc_q + 32'd4;
            end
            if (consume_c) begin
                deliver_pc_n = instr_pc + 32'd4;
            end
        end
        live_n = out_n - disc_n;
        // A raised request is held until granted; otherwise issue only with a free slot.
        req_n  = (ibus_req && !ibus_gnt)
              || ((({1'b0, fifo_cnt_n} + {1'b0, live_n}) < DEPTH_EXT) && (out_n < DEPTH_CNT));
        busy_n = (out_n != '0) || (disc_n != '0) || stale_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            deliver_pc_q <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            stale_q      <= 1'b0;
            out_q        <= '0;
            disc_q       <= '0;
            ibus_req     <= 1'b0;
            fetch_busy   <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_n;
            deliver_pc_q <= deliver_pc_n;
            redir_pc_q   <= redir_pc_n;
            stale_q      <= stale_n;
            out_q        <= out_n;
            disc_q       <= disc_n;
            ibus_req     <= req_n;
            fetch_busy   <= busy_n;
        end
    end

    a_jump_with_flush: assert property (@(posedge clk) disable iff (rst) jump |-> flush)
        else $error("instr_fetch: jump asserted without flush");

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC generation and instruction-fetch front end of the RV32 core. Sits directly upstream of decode/execute and consumes the redirect controls from the core control block (jump, jump_addr, flush, stall_n).
- Issues word fetches on the instruction bus with a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and presents one {pc, instr} per cycle to decode.
- Discards in-flight responses that belong to a squashed path.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
BUF_DEPTH, 2, prefetch FIFO entries; also the cap on outstanding bus transactions (power of 2, ≥2)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
jump  in  1  redirect fetch to jump_addr this cycle
jump_addr  in  32  redirect target; bits [1:0] ignored (treated as 0)
flush  in  1  squash buffered/in-flight instructions (asserted with jump, or alone for interrupt entry)
stall_n  in  1  low: decode does not consume this cycle
ibus_req  out  1  fetch request
ibus_addr  out  32  word-aligned fetch address
ibus_gnt  in  1  request accepted this cycle
ibus_rvalid  in  1  read data valid; in order, ≥1 cycle after its gnt
ibus_rdata  in  32  instruction word
instr_valid  out  1  buffer head valid for decode
instr  out  32  head instruction
instr_pc  out  32  head PC
fetch_busy  out  1  outstanding transactions or pending discards non-zero

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, deliver_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=RUN. All outputs 0 except ibus_addr=RESET_PC.
- ibus_req is asserted the first cycle after reset release.
- Issue rule: ibus_req=1 when fifo_count + outstanding_live < BUF_DEPTH, where outstanding_live excludes transactions marked for discard. Total outstanding (live + discard) never exceeds BUF_DEPTH.
- ibus_addr = fetch_pc.
- Once ibus_req rises, it and ibus_addr hold until ibus_gnt; requests are non-abortable.
- On gnt: fetch_pc += 4 (wraps at 2^32) and outstanding += 1.
- On rvalid with discard_cnt=0: push {pc of that transaction, rdata}. The PC is tracked in a per-transaction PC queue; the FIFO entry is reserved at issue, so a push never overflows.
- Consume: when instr_valid && stall_n && !flush, pop the head and set deliver_pc = instr_pc + 4.
- Head outputs are combinational from FIFO storage.
- Fetch-to-decode latency, empty buffer, zero-wait bus: gnt in cycle N, rvalid N+1, instr_valid N+2.
- flush (with or without jump), same cycle:
  - FIFO cleared; no pop that cycle.
  - discard_cnt = outstanding granted-but-unreturned, minus any rvalid accepted this cycle.
  - A pending ungranted req that is granted later is also counted as discard.
  - New fetch_pc/deliver_pc = jump ? {jump_addr[31:2],2'b00} : deliver_pc (replay from oldest undelivered instruction).
  - If discard_cnt>0, state goes to DRAIN.
- FSM:
  - RUN: normal operation. Goes to DRAIN on flush with non-zero discards.
  - DRAIN: rvalid decrements discard_cnt and data is dropped. New-path requests may issue within the total cap. Returns to RUN when discard_cnt reaches 0. A new flush in DRAIN accumulates further discards and stays in DRAIN.
- Simultaneous events:
  - flush and rvalid in the same cycle: that response is dropped.
  - flush and gnt in the same cycle: that transaction is a discard.
  - stall_n=0 and flush: flush wins.
  - jump without flush: treated as flush (upstream never does this; assertion required).
- Full FIFO with stall_n=0: ibus_req stays low and no data is lost.
- Reset mid-transaction: state cleared immediately. The bus is assumed reset by the same rst.

Decomposition:
- core_pkg additions:
  - RESET_PC_DEFAULT
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
  - typedef enum logic {RUN, DRAIN} fetch_state_e
- Sub-module fetch_buffer: parameterised sync FIFO of fetch_entry_t with clear, push, pop, count. It is reused for the per-transaction PC queue.

Test Plan:
- Reset release, zero-wait bus, stall_n=1 → ibus_addr 0,4,8… each cycle. instr_valid first high 2 cycles after first gnt. instr_pc 0,4,8 with matching rdata.
- gnt delayed 3 cycles → ibus_req and ibus_addr=0x4 held stable; no duplicate fetch; instr sequence unchanged.
- stall_n=0 for 5 cycles → FIFO fills to 2. ibus_req low while count+outstanding=2. Release → delivered PCs continuous, no loss.
- jump=flush=1, jump_addr=0x103, 2 transactions outstanding → next ibus_addr=0x100; 2 responses dropped (fetch_busy high until then); first delivered instr_pc=0x100.
- flush alone after consuming pc 0x8 → refetch from 0xC; first delivered instr_pc=0xC.
- Second flush during DRAIN with 1 pending discard plus 1 new-path outstanding → discard_cnt=2; only third-path data delivered; state returns to RUN.
